omem_write_buffer: RTL and testbench
====================================

OMEM_WRITE_BUFFER -- requirements
Module: omem_write_buffer

Interface
REQ-001 SHALL have parameter OAW, default 19, output-memory word-address width.
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have parameter WB_DEPTH, default 4, write-buffer entries; legal values are powers of two, minimum 2.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port wr_addr  input  OAW  write address from the DSU.
REQ-007 SHALL have port wr_en  input  1  write strobe; one write per cycle.
REQ-008 SHALL have port wr_data  input  DW  write data from the post-processing path.
REQ-009 SHALL have port fb_rd_addr  input  OAW  feedback read address from the DSU.
REQ-010 SHALL have port fb_rd_en  input  1  feedback read strobe.
REQ-011 SHALL have port fb_rd_data  output  DW  feedback read data, valid one cycle after fb_rd_en.
REQ-012 SHALL have port sram_addr  output  OAW  single-port SRAM address.
REQ-013 SHALL have port sram_cs  output  1  SRAM chip select.
REQ-014 SHALL have port sram_we  output  1  SRAM write enable, qualified by sram_cs.
REQ-015 SHALL have port sram_wdata  output  DW  SRAM write data.
REQ-016 SHALL have port sram_rdata  input  DW  SRAM read data, valid one cycle after a read.
REQ-017 SHALL have port wb_count  output  log2(WB_DEPTH)+1  current buffer occupancy.
REQ-018 SHALL have port wb_empty  output  1  high when wb_count is 0; the DSU may switch omem_fb_en only while this is high.
REQ-019 SHALL have port wb_ovf  output  1  sticky flag: a write was dropped.
REQ-020 SHALL have port ovf_clr  input  1  synchronous clear for wb_ovf.

Function
REQ-021 SHALL hold writes in a circular FIFO of WB_DEPTH entries (address plus data), with head and tail pointers that wrap modulo WB_DEPTH.
REQ-022 SHALL give the SRAM port this priority each cycle: fb_rd_en first (cs=1, we=0, addr=fb_rd_addr); otherwise a non-empty FIFO drains its head (cs=1, we=1, addr/wdata from the head entry, pop); otherwise the port is idle (cs=0).
REQ-023 SHALL accept a write when wb_count < WB_DEPTH, or when wb_count = WB_DEPTH and a pop occurs in the same cycle.
REQ-024 SHALL otherwise drop the write, leave the FIFO unchanged and set wb_ovf.
REQ-025 SHALL update wb_count by +1 on push only, -1 on pop only, and leave it unchanged on simultaneous push and pop.
REQ-026 SHALL return fb_rd_data exactly one cycle after fb_rd_en, selecting sram_rdata or forwarded data through a registered select.
REQ-027 SHALL make fb_rd_data hold its last value in cycles with no read response.
REQ-028 SHALL, with forwarding compiled in, compare fb_rd_addr against all valid FIFO entries as held at the start of the cycle; on a hit, the newest matching entry's data is registered and returned instead of sram_rdata.
REQ-029 SHALL NOT forward a write presented in the same cycle as a read to the same address; the read returns the previously stored value.
REQ-030 SHALL let continuous reads starve the drain indefinitely, with no data loss while wb_count < WB_DEPTH.
REQ-031 SHALL give ovf_clr priority over a same-cycle overflow set.

Reset
REQ-032 SHALL, on rst_n low, immediately clear pointers, set wb_count to 0, wb_empty to 1, wb_ovf to 0, sram_cs and sram_we to 0, sram_addr and sram_wdata to 0, fb_rd_data to 0, and clear the forward-select register.
REQ-033 SHALL discard buffered writes when reset is asserted mid-operation; no SRAM write occurs while rst_n is low.

Configuration
REQ-034 SHALL compile the forwarding comparator and its data register only when macro OMEM_WB_FWD_EN is defined.
REQ-035 SHALL, without OMEM_WB_FWD_EN, always return sram_rdata; a read hitting a pending entry returns stale SRAM data, and all other behaviour is unchanged.

Verification
REQ-036 SHALL cover: reset, then a write to addr 0x10 with data 0xA5A5A5A5 -> sram_cs=1, we=1, addr=0x10 next cycle; wb_count 1 then 0.
REQ-037 SHALL cover: 4 writes (0x1-0x4) while fb_rd_en is held high, then a 5th write -> 5th dropped, wb_ovf=1, wb_count=4; ovf_clr -> wb_ovf=0.
REQ-038 SHALL cover, with OMEM_WB_FWD_EN: write 0x20 with 0x11, then 0x20 with 0x22, both pending, then read 0x20 -> fb_rd_data=0x22 one cycle later.
REQ-039 SHALL cover, without OMEM_WB_FWD_EN, the same sequence -> fb_rd_data equals the prior SRAM contents at 0x20.
REQ-040 SHALL cover: a same-cycle write to 0x30 with 0x77 and read of 0x30 (SRAM holds 0x55) -> fb_rd_data=0x55; a later read returns 0x77.
REQ-041 SHALL cover: rst_n asserted with wb_count=3 -> wb_count=0, wb_empty=1 and sram_cs=0 immediately; no further SRAM writes after release.

Source files
------------

// File: rtl/omem_write_buffer.sv
// -----------------------------------------------------------------------------
// omem_write_buffer
//   Small circular write buffer sitting in front of a single-port output-memory
//   SRAM. Writes from the post-processing path are queued (address + data) and
//   drained into the SRAM whenever the port is not needed by a feedback read.
//   Feedback reads always win the SRAM port, so reads return in one cycle and
//   writes may be starved for as long as reads keep coming.
//
//   Optional feature: define OMEM_WB_FWD_EN to compile a forwarding comparator
//   that returns the newest pending buffered write to a read of the same
//   address. Without it, reads always return sram_rdata (possibly stale).
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   wr_addr/en/data   write request, one per cycle
//   fb_rd_addr/en     feedback read request
//   fb_rd_data        feedback read data, one cycle after fb_rd_en, held after
//   sram_*            single-port SRAM interface (read data one cycle later)
//   wb_count/empty    buffer occupancy
//   wb_ovf / ovf_clr  sticky dropped-write flag and its synchronous clear
// -----------------------------------------------------------------------------
module omem_write_buffer #(
  parameter int OAW      = 19,
  parameter int DW       = 32,
  parameter int WB_DEPTH = 4,
  localparam int PW      = $clog2(WB_DEPTH),
  localparam int CW      = PW + 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [OAW-1:0] wr_addr,
  input  logic           wr_en,
  input  logic [DW-1:0]  wr_data,
  input  logic [OAW-1:0] fb_rd_addr,
  input  logic           fb_rd_en,
  output logic [DW-1:0]  fb_rd_data,
  output logic [OAW-1:0] sram_addr,
  output logic           sram_cs,
  output logic           sram_we,
  output logic [DW-1:0]  sram_wdata,
  input  logic [DW-1:0]  sram_rdata,
  output logic [CW-1:0]  wb_count,
  output logic           wb_empty,
  output logic           wb_ovf,
  input  logic           ovf_clr
);

  logic [OAW-1:0] addr_q [WB_DEPTH];
  logic [DW-1:0]  data_q [WB_DEPTH];
  logic [PW-1:0]  head_q, head_d;
  logic [PW-1:0]  tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;
  logic           ovf_q, ovf_d;
  logic           rsp_q;
  logic [DW-1:0]  hold_q;
  logic [DW-1:0]  rsp_data;

  logic empty, full, pop, push, drop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(WB_DEPTH));
  // Reads own the port; the head drains only in read-free cycles.
  assign pop   = ~fb_rd_en & ~empty;
  // A full buffer still accepts a write if the head leaves in the same cycle.
  assign push  = wr_en & (~full | pop);
  assign drop  = wr_en & ~push;

  always_comb begin
    head_d  = pop  ? head_q + PW'(1) : head_q;
    tail_d  = push ? tail_q + PW'(1) : tail_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q;
    if (ovf_clr)   ovf_d = 1'b0;
    else if (drop) ovf_d = 1'b1;
  end

  // SRAM port is driven combinationally so a read issued this cycle returns
  // next cycle; rst_n gates it so nothing reaches the SRAM during reset.
  always_comb begin
    sram_cs    = rst_n & (fb_rd_en | ~empty);
    sram_we    = rst_n & pop;
    sram_addr  = '0;
    sram_wdata = '0;
    if (rst_n && fb_rd_en) sram_addr = fb_rd_addr;
    else if (rst_n && pop) begin
      sram_addr  = addr_q[head_q];
      sram_wdata = data_q[head_q];
    end
  end

`ifdef OMEM_WB_FWD_EN
  logic          hit;
  logic [DW-1:0] hit_data;
  logic [PW-1:0] idx;
  logic          fwd_sel_q;
  logic [DW-1:0] fwd_q;

  // Walk oldest to newest so the newest matching entry wins. Only entries
  // present at the start of the cycle are considered; a same-cycle write is
  // not yet in the array and therefore never forwarded.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int k = 0; k < WB_DEPTH; k++) begin
      idx = head_q + PW'(k);
      if ((CW'(k) < count_q) && (addr_q[idx] == fb_rd_addr)) begin
        hit      = 1'b1;
        hit_data = data_q[idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fwd_sel_q <= 1'b0;
    else        fwd_sel_q <= fb_rd_en & hit;
  end

  always_ff @(posedge clk) begin
    if (fb_rd_en && hit) fwd_q <= hit_data;
  end

  assign rsp_data = fwd_sel_q ? fwd_q : sram_rdata;
`else
  assign rsp_data = sram_rdata;
`endif

  assign fb_rd_data = rsp_q ? rsp_data : hold_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      rsp_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      rsp_q   <= fb_rd_en;
      hold_q  <= fb_rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= wr_addr;
      data_q[tail_q] <= wr_data;
    end
  end

  assign wb_count = count_q;
  assign wb_empty = empty;
  assign wb_ovf   = ovf_q;

endmodule

// File: tb/tb_omem_write_buffer.sv
// -----------------------------------------------------------------------------
// tb_omem_write_buffer
//   Bench for omem_write_buffer with a behavioural SRAM, a queue-based
//   reference model, a per-cycle compare process and directed literal checks
//   followed by randomized traffic. Honors OMEM_WB_FWD_EN like the design.
// -----------------------------------------------------------------------------
module tb_omem_write_buffer;
  localparam int OAW = 19;
  localparam int DW  = 32;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [OAW-1:0] wr_addr = '0;
  logic           wr_en = 1'b0;
  logic [DW-1:0]  wr_data = '0;
  logic [OAW-1:0] fb_rd_addr = '0;
  logic           fb_rd_en = 1'b0;
  logic [DW-1:0]  fb_rd_data;
  logic [OAW-1:0] sram_addr;
  logic           sram_cs, sram_we;
  logic [DW-1:0]  sram_wdata;
  logic [DW-1:0]  sram_rdata = '0;
  logic [2:0]     wb_count;
  logic           wb_empty, wb_ovf;
  logic           ovf_clr = 1'b0;

  omem_write_buffer #(.OAW(OAW), .DW(DW), .WB_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_addr(wr_addr), .wr_en(wr_en), .wr_data(wr_data),
    .fb_rd_addr(fb_rd_addr), .fb_rd_en(fb_rd_en), .fb_rd_data(fb_rd_data),
    .sram_addr(sram_addr), .sram_cs(sram_cs), .sram_we(sram_we),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .wb_count(wb_count), .wb_empty(wb_empty), .wb_ovf(wb_ovf),
    .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  function automatic logic [DW-1:0] init_val(input logic [OAW-1:0] a);
    return 32'hC0DE0000 ^ {13'd0, a};
  endfunction

  // Behavioural single-port SRAM with one-cycle read latency.
  logic [DW-1:0] sram_mem [logic [OAW-1:0]];
  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_we) sram_mem[sram_addr] = sram_wdata;
      else sram_rdata <= sram_mem.exists(sram_addr) ? sram_mem[sram_addr] : init_val(sram_addr);
    end
  end

  // Reference model: pending writes as a queue, SRAM contents as a map.
  typedef struct { logic [OAW-1:0] a; logic [DW-1:0] d; } ent_t;
  ent_t          q[$];
  logic [DW-1:0] ref_mem [logic [OAW-1:0]];
  logic          m_ovf = 1'b0;
  logic [DW-1:0] m_fb  = '0;
  logic [DW-1:0] v;
  logic          dropped;

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_ovf = 1'b0;
      m_fb  = '0;
    end else begin
      dropped = 1'b0;
      if (fb_rd_en) begin
        v = ref_mem.exists(fb_rd_addr) ? ref_mem[fb_rd_addr] : init_val(fb_rd_addr);
`ifdef OMEM_WB_FWD_EN
        foreach (q[i]) if (q[i].a == fb_rd_addr) v = q[i].d;
`endif
        m_fb = v;
      end else if (q.size() > 0) begin
        ref_mem[q[0].a] = q[0].d;
        void'(q.pop_front());
      end
      if (wr_en) begin
        if (q.size() < DEPTH) q.push_back('{a: wr_addr, d: wr_data});
        else dropped = 1'b1;
      end
      if (ovf_clr) m_ovf = 1'b0;
      else if (dropped) m_ovf = 1'b1;
    end
  end

  // Compare process: every falling edge.
  int  n_exp;
  logic e_cs, e_we;
  always @(negedge clk) begin
    n_exp = rst_n ? q.size() : 0;
    e_cs  = rst_n && (fb_rd_en || n_exp > 0);
    e_we  = rst_n && !fb_rd_en && n_exp > 0;
    chk("wb_count", 64'(wb_count), 64'(n_exp));
    chk("wb_empty", 64'(wb_empty), 64'(n_exp == 0));
    chk("wb_ovf", 64'(wb_ovf), 64'(rst_n ? m_ovf : 1'b0));
    chk("fb_rd_data", 64'(fb_rd_data), 64'(rst_n ? m_fb : '0));
    chk("sram_cs", 64'(sram_cs), 64'(e_cs));
    chk("sram_we", 64'(sram_we), 64'(e_we));
    if (e_cs) chk("sram_addr", 64'(sram_addr), 64'(fb_rd_en ? fb_rd_addr : q[0].a));
    if (e_we) chk("sram_wdata", 64'(sram_wdata), 64'(q[0].d));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    wr_en = 1'b0; fb_rd_en = 1'b0; ovf_clr = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("reset_count", 64'(wb_count), 64'd0);
    chk("reset_empty", 64'(wb_empty), 64'd1);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Single write drains in the following cycle.
    wr_en = 1'b1; wr_addr = 19'h10; wr_data = 32'hA5A5A5A5;
    tick();
    wr_en = 1'b0;
    #1;
    chk("w1_cs", 64'(sram_cs), 64'd1);
    chk("w1_we", 64'(sram_we), 64'd1);
    chk("w1_addr", 64'(sram_addr), 64'h10);
    chk("w1_wdata", 64'(sram_wdata), 64'hA5A5A5A5);
    chk("w1_count1", 64'(wb_count), 64'd1);
    tick();
    chk("w1_count0", 64'(wb_count), 64'd0);
    idle(2);

    // Fill under starving reads, then overflow and clear.
    fb_rd_en = 1'b1; fb_rd_addr = 19'h100;
    for (int i = 1; i <= 5; i++) begin
      wr_en = 1'b1; wr_addr = OAW'(i); wr_data = DW'(i);
      tick();
    end
    wr_en = 1'b0;
    #1;
    chk("ovf_count", 64'(wb_count), 64'd4);
    chk("ovf_set", 64'(wb_ovf), 64'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    #1;
    chk("ovf_clr", 64'(wb_ovf), 64'd0);
    idle(6);

    // Two pending writes to one address, then a read of it.
    fb_rd_en = 1'b1; fb_rd_addr = 19'h101;
    wr_en = 1'b1; wr_addr = 19'h20; wr_data = 32'h11;
    tick();
    wr_data = 32'h22;
    tick();
    wr_en = 1'b0; fb_rd_addr = 19'h20;
    tick();
    fb_rd_en = 1'b0;
    #1;
`ifdef OMEM_WB_FWD_EN
    chk("fwd_newest", 64'(fb_rd_data), 64'h22);
`else
    chk("nofwd_stale", 64'(fb_rd_data), 64'hC0DE0020);
`endif
    idle(4);

    // Same-cycle write and read of one address returns the stored value.
    wr_en = 1'b1; wr_addr = 19'h30; wr_data = 32'h55;
    tick();
    idle(3);
    fb_rd_en = 1'b1; fb_rd_addr = 19'h30;
    wr_en = 1'b1; wr_addr = 19'h30; wr_data = 32'h77;
    tick();
    fb_rd_en = 1'b0; wr_en = 1'b0;
    #1;
    chk("same_cyc_old", 64'(fb_rd_data), 64'h55);
    idle(3);
    fb_rd_en = 1'b1; fb_rd_addr = 19'h30;
    tick();
    fb_rd_en = 1'b0;
    #1;
    chk("later_new", 64'(fb_rd_data), 64'h77);
    idle(2);

    // Reset with three pending writes while a read is still requested.
    fb_rd_en = 1'b1; fb_rd_addr = 19'h102;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_addr = OAW'(19'h40 + i); wr_data = DW'(32'hBEEF0000 + i);
      tick();
    end
    wr_en = 1'b0;
    #1;
    chk("pre_rst_count", 64'(wb_count), 64'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_count", 64'(wb_count), 64'd0);
    chk("mid_rst_empty", 64'(wb_empty), 64'd1);
    chk("mid_rst_cs", 64'(sram_cs), 64'd0);
    chk("mid_rst_fb", 64'(fb_rd_data), 64'd0);
    fb_rd_en = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_we", 64'(sram_we), 64'd0);
    end

    // Randomized traffic on a small address window to provoke hits.
    for (int c = 0; c < 3000; c++) begin
      int rd_pct;
      rd_pct     = ((c / 300) % 2 == 0) ? 40 : 80;
      wr_en      = ($urandom_range(99) < 60);
      wr_addr    = OAW'($urandom_range(15));
      wr_data    = $urandom;
      fb_rd_en   = ($urandom_range(99) < rd_pct);
      fb_rd_addr = OAW'($urandom_range(15));
      ovf_clr    = ($urandom_range(99) < 5);
      tick();
    end
    idle(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
